// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline-boundary registers.
// Contents:
//   pipe_state_t     : occupancy of a skid register (EMPTY / ONE / FULL)
//   EXE2MEM_*, MEM2WB_* : per-boundary control / data bundle widths
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  localparam int EXE2MEM_CTRL_W = 3;
  localparam int EXE2MEM_DATA_W = 101;
  localparam int MEM2WB_CTRL_W  = 2;
  localparam int MEM2WB_DATA_W  = 69;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones once reached.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset, clears the count
//   inc   : increment request for this cycle
//   count : current count
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic stage-boundary register with a 2-entry skid buffer.
// A control bundle and a data bundle move under a valid/ready handshake;
// both in_ready and out_valid are registered, so no combinational path
// crosses the boundary. Control bits are zeroed in empty / killed slots so
// an empty slot always reads as a bubble. Data is only cleared by reset.
//
// Optional build macro: PIPE_SKID_STATS_EN adds the stall_cycles output
// (saturating count of cycles with out_valid & !out_ready; reset-only clear).
//
// Ports:
//   clk, rst          : clock (rising edge), async active-low reset
//   flush             : synchronous kill of all contents
//   in_valid/in_ready : upstream handshake (in_ready registered)
//   in_ctrl, in_data  : upstream bundles
//   out_valid/out_ready : downstream handshake (out_valid registered)
//   out_ctrl, out_data  : main-entry bundles
//   stall_cycles      : stall statistics (PIPE_SKID_STATS_EN only)
//
// state | meaning
// EMPTY | no valid entry
// ONE   | main entry valid, skid empty
// FULL  | main and skid entries valid, upstream stalled
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 3,
  parameter int DATA_W = 101,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_SKID_STATS_EN
  ,
  output logic [STAT_W-1:0] stall_cycles
`endif
);

  pipe_state_t       state_q, state_d;
  logic              main_valid_q, main_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_ready_q, in_ready_d;

  logic xfer_in;

  // in_ready_q is low for the first cycle after reset, so gating with it
  // keeps that cycle from accepting an entry.
  assign xfer_in = in_valid & in_ready_q;

  always_comb begin
    state_d      = state_q;
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;

    if (flush) begin
      // Data is left in place; the zeroed control makes both slots bubbles.
      state_d      = EMPTY;
      main_valid_d = 1'b0;
      main_ctrl_d  = '0;
      skid_valid_d = 1'b0;
      skid_ctrl_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (xfer_in) begin
            main_valid_d = 1'b1;
            main_ctrl_d  = in_ctrl;
            main_data_d  = in_data;
            state_d      = ONE;
          end
        end
        ONE: begin
          if (xfer_in && out_ready) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (xfer_in) begin
            skid_valid_d = 1'b1;
            skid_ctrl_d  = in_ctrl;
            skid_data_d  = in_data;
            state_d      = FULL;
          end else if (out_ready) begin
            main_valid_d = 1'b0;
            main_ctrl_d  = '0;
            state_d      = EMPTY;
          end
        end
        FULL: begin
          if (out_ready) begin
            main_ctrl_d  = skid_ctrl_q;
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
            skid_ctrl_d  = '0;
            state_d      = ONE;
          end
        end
        default: begin
          state_d      = EMPTY;
          main_valid_d = 1'b0;
          main_ctrl_d  = '0;
          skid_valid_d = 1'b0;
          skid_ctrl_d  = '0;
        end
      endcase
    end

    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= EMPTY;
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;

`ifdef PIPE_SKID_STATS_EN
  sat_counter #(
    .WIDTH(STAT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (main_valid_q & ~out_ready),
    .count(stall_cycles)
  );
`else
  // STAT_W has no consumer when the stall counter is compiled out.
  logic [STAT_W-1:0] unused_stat_w;
  assign unused_stat_w = '0;
`endif

endmodule
